vco_adc_capture: RTL and testbench

VCO_ADC_CAPTURE -- requirements
Module: vco_adc_capture

---
 rtl/vco_adc_capture.sv | 201 ++++++++++++++++++++
 tb/tb_vco_adc_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vco_adc_capture.sv
// vco_adc_capture: captures VCO-ADC samples into a FIFO under control of a
// small IDLE/CAPTURE/DONE state machine, and returns them through a one-word
// read port.
// Optional feature: define VCO_ADC_CAPTURE_IRQ_EN to add threshold_in and a
// registered irq_out.
module vco_adc_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic                  clear_in,
  input  logic [9:0]            capture_len_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  rd_req_in,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  output logic [ADDR_WIDTH:0]   count_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic                  overflow_out,
  output logic                  busy_out,
  output logic                  done_out
`ifdef VCO_ADC_CAPTURE_IRQ_EN
  ,
  input  logic [ADDR_WIDTH:0]   threshold_in,
  output logic                  irq_out
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [9:0]              sample_cnt_q, sample_cnt_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    wr_en_s, rd_en_s, full_s;

  assign full_s = (count_q == FULL_CNT);

  // Next-state, FIFO pointer/occupancy and read-port logic; clear_in wins over everything.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    sample_cnt_d = sample_cnt_q;
    overflow_d   = overflow_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    if (clear_in) begin
      state_d      = IDLE;
      wr_ptr_d     = {ADDR_WIDTH{1'b0}};
      rd_ptr_d     = {ADDR_WIDTH{1'b0}};
      count_d      = {(ADDR_WIDTH+1){1'b0}};
      sample_cnt_d = 10'd0;
      overflow_d   = 1'b0;
    end else begin
      // A read of an empty FIFO is ignored, so a simultaneous write to an empty FIFO is write-only.
      rd_en_s = rd_req_in && (count_q != {(ADDR_WIDTH+1){1'b0}});
      case (state_q)
        IDLE, DONE: begin
          if (start_in) begin
            state_d      = CAPTURE;
            sample_cnt_d = 10'd0;
            overflow_d   = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        CAPTURE: begin
          if (data_valid_in) begin
            // Every strobe counts toward the capture length, even a dropped one.
            sample_cnt_d = sample_cnt_q + 10'd1;
            if (full_s && !rd_en_s) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_s = 1'b1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q;
          end
          if (stop_in) begin
            state_d = DONE;
          end else if ((capture_len_in != 10'd0) && (sample_cnt_d == capture_len_in)) begin
            state_d = DONE;
          end else begin
            state_d = CAPTURE;
          end
        end
        default: state_d = IDLE;
      endcase

      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase

      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (rd_en_s) begin
        rd_ptr_d   = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
      end
    end
  end

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q     <= {ADDR_WIDTH{1'b0}};
      count_q      <= {(ADDR_WIDTH+1){1'b0}};
      sample_cnt_q <= 10'd0;
      overflow_q   <= 1'b0;
      rd_data_q    <= {DATA_WIDTH{1'b0}};
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sample_cnt_q <= sample_cnt_d;
      overflow_q   <= overflow_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // FIFO storage; contents are unobservable after reset because count is zeroed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign rd_data_out  = rd_data_q;
  assign rd_valid_out = rd_valid_q;
  assign count_out    = count_q;
  assign empty_out    = (count_q == {(ADDR_WIDTH+1){1'b0}});
  assign full_out     = full_s;
  assign overflow_out = overflow_q;
  assign busy_out     = (state_q == CAPTURE);
  assign done_out     = (state_q == DONE);

`ifdef VCO_ADC_CAPTURE_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt condition, evaluated from registered status so irq_out lags it by one cycle.
  always_comb begin
    irq_d = 1'b0;
    if ((threshold_in != {(ADDR_WIDTH+1){1'b0}}) && (count_q >= threshold_in)) begin
      irq_d = 1'b1;
    end else if (overflow_q || (state_q == DONE)) begin
      irq_d = 1'b1;
    end else begin
      irq_d = 1'b0;
    end
  end

  // Interrupt output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_out = irq_q;
`endif

endmodule

// File: tb/tb_vco_adc_capture.sv
// Directed self-checking bench for vco_adc_capture (DATA_WIDTH=32, ADDR_WIDTH=4).
module tb_vco_adc_capture;

  logic        clk;
  logic        rstn;
  logic        start_in, stop_in, clear_in;
  logic [9:0]  capture_len_in;
  logic [31:0] data_in;
  logic        data_valid_in;
  logic        rd_req_in;
  logic [31:0] rd_data_out;
  logic        rd_valid_out;
  logic [4:0]  count_out;
  logic        empty_out, full_out, overflow_out, busy_out, done_out;
`ifdef VCO_ADC_CAPTURE_IRQ_EN
  logic [4:0]  threshold_in;
  logic        irq_out;
`endif

  int n_checks = 0;
  int n_passed = 0;

  vco_adc_capture #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .clear_in      (clear_in),
    .capture_len_in(capture_len_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .rd_req_in     (rd_req_in),
    .rd_data_out   (rd_data_out),
    .rd_valid_out  (rd_valid_out),
    .count_out     (count_out),
    .empty_out     (empty_out),
    .full_out      (full_out),
    .overflow_out  (overflow_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
`ifdef VCO_ADC_CAPTURE_IRQ_EN
    ,
    .threshold_in  (threshold_in),
    .irq_out       (irq_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; start_in = 1'b0; stop_in = 1'b0; clear_in = 1'b0;
    capture_len_in = 10'd5; data_in = 32'd0; data_valid_in = 1'b0; rd_req_in = 1'b0;
`ifdef VCO_ADC_CAPTURE_IRQ_EN
    threshold_in = 5'd0;
`endif
    #1;
    // Reset values
    check("rst_count", count_out, 64'd0);
    check("rst_empty", empty_out, 64'd1);
    check("rst_full", full_out, 64'd0);
    check("rst_ovf", overflow_out, 64'd0);
    check("rst_busy", busy_out, 64'd0);
    check("rst_done", done_out, 64'd0);
    check("rst_rdv", rd_valid_out, 64'd0);
    check("rst_rdd", rd_data_out, 64'd0);
    tick(); tick();

    // Length-5 capture; start honoured on first edge after reset release
    rstn = 1'b1; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("t1_busy", busy_out, 64'd1);
    for (int i = 1; i <= 5; i++) begin
      data_in = 32'(i); data_valid_in = 1'b1;
      tick();
      if (i == 4) begin
        check("t1_busy4", busy_out, 64'd1);
        check("t1_done4", done_out, 64'd0);
      end
    end
    data_valid_in = 1'b0;
    check("t1_done", done_out, 64'd1);
    check("t1_busy5", busy_out, 64'd0);
    check("t1_count", count_out, 64'd5);
    for (int i = 1; i <= 5; i++) begin
      rd_req_in = 1'b1;
      tick();
      rd_req_in = 1'b0;
      check("t1_rdv", rd_valid_out, 64'd1);
      check("t1_rdd", rd_data_out, 64'(i));
      tick();
      check("t1_rdv_pulse", rd_valid_out, 64'd0);
      check("t1_rdd_hold", rd_data_out, 64'(i));
    end
    check("t1_empty", empty_out, 64'd1);

    // Read while empty
    rd_req_in = 1'b1;
    tick();
    rd_req_in = 1'b0;
    check("t2_rdv_empty", rd_valid_out, 64'd0);
    check("t2_rdd_hold", rd_data_out, 64'd5);

    // Continuous capture, 20 strobes, overflow
    capture_len_in = 10'd0; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_in = 32'(100 + i); data_valid_in = 1'b1;
      tick();
    end
    data_valid_in = 1'b0;
    check("t3_count", count_out, 64'd16);
    check("t3_full", full_out, 64'd1);
    check("t3_ovf", overflow_out, 64'd1);
    check("t3_busy", busy_out, 64'd1);
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    check("t3_done", done_out, 64'd1);

    // Re-arm with full FIFO; simultaneous read and write
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("t4_ovf_clr", overflow_out, 64'd0);
    check("t4_count_kept", count_out, 64'd16);
    rd_req_in = 1'b1; data_valid_in = 1'b1; data_in = 32'd200;
    tick();
    rd_req_in = 1'b0; data_valid_in = 1'b0;
    check("t4_count", count_out, 64'd16);
    check("t4_ovf", overflow_out, 64'd0);
    check("t4_rdv", rd_valid_out, 64'd1);
    check("t4_rdd", rd_data_out, 64'd100);
    start_in = 1'b1; stop_in = 1'b1;
    tick();
    start_in = 1'b0; stop_in = 1'b0;
    check("t4_startstop_done", done_out, 64'd1);
    check("t4_startstop_busy", busy_out, 64'd0);
    rd_req_in = 1'b1;
    tick();
    rd_req_in = 1'b0;
    check("t4_rdd2", rd_data_out, 64'd101);
    check("t4_count2", count_out, 64'd15);

    // Clear mid-capture overrides start/stop/read/write
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("t5_busy", busy_out, 64'd1);
    clear_in = 1'b1; stop_in = 1'b1; rd_req_in = 1'b1; data_valid_in = 1'b1; data_in = 32'd7;
    tick();
    clear_in = 1'b0; rd_req_in = 1'b0; data_valid_in = 1'b0;
    check("t5_idle_busy", busy_out, 64'd0);
    check("t5_idle_done", done_out, 64'd0);
    check("t5_count", count_out, 64'd0);
    check("t5_empty", empty_out, 64'd1);
    check("t5_rdv", rd_valid_out, 64'd0);
    tick();
    stop_in = 1'b0;
    check("t5_stop_ignored", done_out, 64'd0);
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    check("t5_idle_nowrite", count_out, 64'd0);

    // Async reset mid-capture with 7 words
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in = 32'(300 + i); data_valid_in = 1'b1;
      tick();
    end
    data_valid_in = 1'b0;
    check("t6_count7", count_out, 64'd7);
    rd_req_in = 1'b1;
    tick();
    rd_req_in = 1'b0;
    check("t6_rdd", rd_data_out, 64'd300);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_count", count_out, 64'd0);
    check("t6_empty", empty_out, 64'd1);
    check("t6_busy", busy_out, 64'd0);
    check("t6_rdd_rst", rd_data_out, 64'd0);
    check("t6_rdv_rst", rd_valid_out, 64'd0);
`ifdef VCO_ADC_CAPTURE_IRQ_EN
    check("t6_irq_rst", irq_out, 64'd0);
`endif
    rstn = 1'b1; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("t6_restart", busy_out, 64'd1);
    check("t6_restart_cnt", count_out, 64'd0);

`ifdef VCO_ADC_CAPTURE_IRQ_EN
    // Threshold interrupt
    threshold_in = 5'd4;
    tick();
    for (int i = 0; i < 4; i++) begin
      data_in = 32'(400 + i); data_valid_in = 1'b1;
      tick();
      check("t7_irq_low", irq_out, 64'd0);
    end
    data_valid_in = 1'b0;
    check("t7_count4", count_out, 64'd4);
    tick();
    check("t7_irq_rise", irq_out, 64'd1);
    rd_req_in = 1'b1;
    tick();
    rd_req_in = 1'b0;
    check("t7_irq_still", irq_out, 64'd1);
    tick();
    check("t7_irq_fall", irq_out, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
